// File: rtl/j_div_pkg.sv
// Shared constants and state encoding for the sequential 32-bit divider.
// Build option: define JDIV_OFFSET_EN to include 16.16 offset mode (48-bit numerator, 48 iterations).
package j_div_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned ITER_NORM = 32;
    localparam int unsigned ITER_OFS  = 48;
    localparam int unsigned CNT_W     = 6;

`ifdef JDIV_OFFSET_EN
    localparam int unsigned NUM_W = 48;
`else
    localparam int unsigned NUM_W = 32;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/j_div_step.sv
// One restoring-division step: shift the next numerator bit into the partial
// remainder, then trial-subtract the divisor and keep the result if it is non-negative.
// Ports:
//   i_rem      partial remainder in
//   i_divisor  divisor
//   i_bit      next numerator bit (MSB first)
//   o_rem_c    partial remainder out (combinational)
//   o_qbit_c   quotient bit, the inverted borrow (combinational)
module j_div_step
    import j_div_pkg::*;
(
    input  logic [DIV_W-1:0] i_rem,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic             i_bit,
    output logic [DIV_W-1:0] o_rem_c,
    output logic             o_qbit_c
);

    logic [DIV_W:0] w_shift;
    logic [DIV_W:0] w_diff;
    logic           w_borrow;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // A set shifted MSB already exceeds any 32-bit divisor; otherwise the
    // 33-bit difference MSB is the borrow.
    assign w_borrow = ~w_shift[DIV_W] & w_diff[DIV_W];

    assign o_qbit_c = ~w_borrow;
    assign o_rem_c  = w_borrow ? w_shift[DIV_W-1:0] : w_diff[DIV_W-1:0];

endmodule

// File: rtl/j_div32_seq.sv
// Sequential unsigned 32-bit restoring divider, one quotient bit per clock.
// Result (quotient, remainder) is written on the last iteration and held until
// the next completed operation; done pulses one cycle as the FSM returns to IDLE.
// Build option: JDIV_OFFSET_EN enables 16.16 mode (numerator = dividend<<16, 48 steps,
// low 32 quotient bits kept). Without it offset is ignored.
// Ports:
//   sys_clk, resetl        clock, async active-low reset
//   start                  request, sampled in IDLE only
//   dividend, divisor      operands, sampled with start
//   offset                 16.16 mode select, sampled with start
//   busy                   high in RUN and DONE
//   done                   one-cycle result-valid pulse
//   quotient, remainder    results
module j_div32_seq
    import j_div_pkg::*;
(
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    input  logic             offset,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [NUM_W-1:0] r_num;

    logic [NUM_W-1:0] w_num_load;
    logic [CNT_W-1:0] w_iter_load;
    logic [DIV_W-1:0] w_rem_next;
    logic             w_qbit;

    // Numerator and iteration count chosen at start
`ifdef JDIV_OFFSET_EN
    assign w_num_load  = offset ? {dividend, 16'h0000} : {16'h0000, dividend};
    assign w_iter_load = offset ? CNT_W'(ITER_OFS) : CNT_W'(ITER_NORM);
`else
    logic w_unused_offset;
    assign w_unused_offset = offset;
    assign w_num_load      = dividend;
    assign w_iter_load     = CNT_W'(ITER_NORM);
`endif

    j_div_step u_step (
        .i_rem     (r_rem),
        .i_divisor (r_div),
        .i_bit     (r_num[NUM_W-1]),
        .o_rem_c   (w_rem_next),
        .o_qbit_c  (w_qbit)
    );

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_num     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        busy    <= 1'b1;
                        r_div   <= divisor;
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_num   <= w_num_load;
                        r_cnt   <= w_iter_load;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[DIV_W-2:0], w_qbit};
                    r_num <= {r_num[NUM_W-2:0], 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last step: publish the result directly from the step logic
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= DONE;
                        quotient  <= {r_quo[DIV_W-2:0], w_qbit};
                        remainder <= w_rem_next;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_j_div32_seq.sv
// Directed bench for j_div32_seq: vector table plus multi-cycle corner sequences.
module tb_j_div32_seq;

    logic        sys_clk;
    logic        resetl;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        offset;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    j_div32_seq dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .offset    (offset),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        ofs;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Starts an operation (caller is at #1 after an edge, DUT idle) and waits for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ofs,
                          input string name, output int lat,
                          output logic [31:0] q, output logic [31:0] r);
        dividend = a;
        divisor  = b;
        offset   = ofs;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        check({name, "_busy_after_start"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        q = quotient;
        r = remainder;
    endtask

    initial begin
        int          lat;
        int          n_done;
        int          done_at[$];
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] q_seen[$];
        logic [31:0] r_seen[$];

        vecs[0]  = '{"d100_7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
        vecs[1]  = '{"div_by_0",   32'h12345678,   32'h0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   33};
`ifdef JDIV_OFFSET_EN
        vecs[2]  = '{"ofs_1_2",    32'd1,          32'd2,          1'b1, 32'h00008000,   32'd0,          49};
        vecs[3]  = '{"ofs_3_2",    32'd3,          32'd2,          1'b1, 32'h00018000,   32'd0,          49};
        vecs[4]  = '{"ofs_trunc",  32'h00020000,   32'd1,          1'b1, 32'd0,          32'd0,          49};
`else
        vecs[2]  = '{"ofs_1_2",    32'd1,          32'd2,          1'b1, 32'd0,          32'd1,          33};
        vecs[3]  = '{"ofs_3_2",    32'd3,          32'd2,          1'b1, 32'd1,          32'd1,          33};
        vecs[4]  = '{"ofs_trunc",  32'h00020000,   32'd1,          1'b1, 32'h00020000,   32'd0,          33};
`endif
        vecs[5]  = '{"max_by_1",   32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          33};
        vecs[6]  = '{"zero_num",   32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          33};
        vecs[7]  = '{"small_big",  32'd5,          32'hFFFFFFFF,   1'b0, 32'd0,          32'd5,          33};
        vecs[8]  = '{"max_max",    32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          33};
        vecs[9]  = '{"msb_by_3",   32'h80000000,   32'd3,          1'b0, 32'h2AAAAAAA,   32'd2,          33};
        vecs[10] = '{"d12345_100", 32'd12345,      32'd100,        1'b0, 32'd123,        32'd45,         33};
        vecs[11] = '{"d81_9",      32'd81,         32'd9,          1'b0, 32'd9,          32'd0,          33};

        resetl   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        offset   = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        resetl = 1'b1;
        repeat (2) tick();

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ofs, vecs[i].name, lat, q, r);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_quotient"}, 64'(q), 64'(vecs[i].q));
            check({vecs[i].name, "_remainder"}, 64'(r), 64'(vecs[i].r));
            tick();
            check({vecs[i].name, "_done_one_cycle"}, 64'(done), 64'd0);
            check({vecs[i].name, "_busy_low_after"}, 64'(busy), 64'd0);
            dividend = ~vecs[i].a;
            divisor  = ~vecs[i].b;
            repeat (3) tick();
            check({vecs[i].name, "_hold_q"}, 64'(quotient), 64'(vecs[i].q));
            check({vecs[i].name, "_hold_r"}, 64'(remainder), 64'(vecs[i].r));
        end

        // Second start during an operation is ignored
        dividend = 32'hFFFFFFFF;
        divisor  = 32'd1;
        offset   = 1'b0;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        n_done = 0;
        done_at.delete();
        for (int e = 1; e <= 80; e++) begin
            if (e == 10) begin
                dividend = 32'd5;
                divisor  = 32'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                n_done++;
                done_at.push_back(e);
                q = quotient;
                r = remainder;
            end
        end
        check("ign_start_done_count", 64'(n_done), 64'd1);
        check("ign_start_done_edge", 64'(done_at.size() > 0 ? done_at[0] : -1), 64'd33);
        check("ign_start_quotient", 64'(q), 64'hFFFFFFFF);
        check("ign_start_remainder", 64'(r), 64'd0);

        // Reset mid-operation
        dividend = 32'h1234;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        resetl = 1'b0;
        #2;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_quotient", 64'(quotient), 64'd0);
        check("midrst_remainder", 64'(remainder), 64'd0);
        tick();
        check("midrst_hold_busy", 64'(busy), 64'd0);
        check("midrst_hold_quotient", 64'(quotient), 64'd0);
        resetl = 1'b1;
        n_done = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        run_op(32'd81, 32'd9, 1'b0, "post_rst", lat, q, r);
        check("post_rst_latency", 64'(lat), 64'd33);
        check("post_rst_quotient", 64'(q), 64'd9);
        check("post_rst_remainder", 64'(r), 64'd0);
        tick();

        // Start held high: back-to-back operations every 34 cycles
        dividend = 32'd7;
        divisor  = 32'd7;
        offset   = 1'b0;
        start    = 1'b1;
        tick();
        done_at.delete();
        q_seen.delete();
        r_seen.delete();
        for (int e = 1; e <= 110; e++) begin
            tick();
            if (done === 1'b1) begin
                done_at.push_back(e);
                q_seen.push_back(quotient);
                r_seen.push_back(remainder);
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(done_at.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < done_at.size()) begin
                check($sformatf("b2b_done_edge_%0d", k), 64'(done_at[k]), 64'(33 + 34 * k));
                check($sformatf("b2b_quotient_%0d", k), 64'(q_seen[k]), 64'd1);
                check($sformatf("b2b_remainder_%0d", k), 64'(r_seen[k]), 64'd0);
            end
        end
        lat = 0;
        while (busy !== 1'b0 && lat < 60) begin
            tick();
            lat++;
        end
        check("b2b_drain_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/j_div32_seq.md
J_DIV32_SEQ -- requirements
Module: j_div32_seq

Interface
REQ-001 SHALL have port sys_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port resetl, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 32, unsigned numerator; sampled with start.
REQ-005 SHALL have port divisor, input, 32, unsigned denominator; sampled with start.
REQ-006 SHALL have port offset, input, 1, 16.16 mode: numerator becomes dividend<<16; sampled with start.
REQ-007 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-009 SHALL have port quotient, output, 32, unsigned quotient, low 32 bits.
REQ-010 SHALL have port remainder, output, 32, unsigned remainder.

Function
REQ-011 SHALL implement the states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when the iteration count is exhausted; DONE->IDLE unconditionally.
REQ-012 SHALL, on start in IDLE, latch divisor, clear the partial remainder, load the numerator shift register, and set the iteration count N: 32 normally, 48 with offset.
REQ-013 SHALL perform one restoring step per RUN cycle: shift the next numerator MSB into the remainder, form a 33-bit trial subtraction of the divisor, keep the difference if it is non-negative, and shift the inverted borrow into the quotient LSB.
REQ-014 SHALL assert done for exactly one cycle, N+1 clock edges after the edge that sampled start (33 or 49).
REQ-015 SHALL hold quotient and remainder stable from done until the next accepted start; the results update only in RUN.
REQ-016 SHALL ignore start while busy; there is no queueing.
REQ-017 SHALL accept a start asserted in the same cycle that DONE returns to IDLE on the following edge only.
REQ-018 SHALL produce, for divisor=0 via the natural restoring result, quotient=0xFFFFFFFF and remainder equal to the low 32 bits of the numerator; no error flag is raised.
REQ-019 SHALL, in offset mode, keep only the low 32 bits of the 48-bit quotient; the upper bits are discarded silently.
REQ-020 SHALL base remainder arithmetic on 33 bits internally; the remainder output is always less than the divisor when the divisor is nonzero.

Reset
REQ-021 SHALL, while resetl is low, force the state to IDLE, busy=0, done=0, quotient=0, remainder=0, and clear the iteration counter, independent of sys_clk.
REQ-022 SHALL abandon any operation in progress when reset asserts mid-operation; no done is issued for it, and the first start after deassertion begins a fresh operation.

Configuration
REQ-023 SHALL use the macro JDIV_OFFSET_EN; when it is defined, offset mode, 48-bit numerator handling and N=48 are built.
REQ-024 SHALL, when JDIV_OFFSET_EN is undefined, ignore the offset input, fix N at 32, size the shift register at 32 bits, and have the 16.16 logic absent.

Structure
REQ-025 SHALL place in package j_div_pkg: the state encoding (IDLE, RUN, DONE), width constant 32, and iteration constants 32 and 48.
REQ-026 SHALL implement the 33-bit trial subtraction and select in sub-module j_div_step (combinational: remainder in, divisor, next bit -> new remainder, quotient bit); the rest is control and registers in j_div32_seq.

Verification
REQ-027 SHALL verify: dividend=100, divisor=7, offset=0 -> done on edge 33, quotient=14, remainder=2, busy low the cycle after done.
REQ-028 SHALL verify: dividend=0x12345678, divisor=0 -> quotient=0xFFFFFFFF, remainder=0x12345678, no hang.
REQ-029 SHALL verify (JDIV_OFFSET_EN): dividend=1, divisor=2, offset=1 -> done on edge 49, quotient=0x00008000, remainder=0; without the macro the same stimulus gives quotient=0, remainder=1 on edge 33.
REQ-030 SHALL verify: start pulsed again at cycle 10 with new operands during 0xFFFFFFFF/1 -> ignored, quotient=0xFFFFFFFF, remainder=0, single done.
REQ-031 SHALL verify: resetl dropped at cycle 15 of a division, released, then 81/9 started -> no done for the aborted run, all outputs 0 during reset, then quotient=9, remainder=0.
REQ-032 SHALL verify: start held high continuously with 7/7 -> back-to-back operations, done every 34 cycles, each quotient=1, remainder=0.
